// File: rtl/cpu_types_pkg.sv
// Shared pipeline type definitions: per-stage control state and
// elastic-stage occupancy encoding.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    PS_IDLE  = 2'b00,
    PS_RUN   = 2'b01,
    PS_STALL = 2'b10,
    PS_FLUSH = 2'b11
  } pipe_state_t;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    HALF  = 2'b01,
    FULL  = 2'b10
  } pipe_occ_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; synchronous clear.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge CLK) begin
    if (RST) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipeline_elastic_stage.sv
// Two-entry elastic pipeline stage (main + skid register) with flush and a
// saturating downstream-stall counter.
module pipeline_elastic_stage
  import cpu_types_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  input  logic             flush,
  output logic [1:0]       occ,
  output logic [CNT_W-1:0] stall_cnt
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both 1. in_ready/out_valid depend only on occ_q, so neither side sees a
  // combinational path through this stage.

  pipe_occ_t        occ_q, occ_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             accept, deliver;

  assign in_ready  = (occ_q != FULL);
  assign out_valid = (occ_q != EMPTY);
  assign out_data  = main_q;
  assign occ       = occ_q;

  assign accept  = in_valid & in_ready;
  assign deliver = out_valid & out_ready;

  always_ff @(posedge CLK) begin
    if (RST) begin
      occ_q  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      occ_q  <= occ_d;
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end

  // Vacated registers are zeroed so out_data reads 0 whenever nothing is held.
  always_comb begin
    occ_d  = occ_q;
    main_d = main_q;
    skid_d = skid_q;
    if (flush) begin
      occ_d  = EMPTY;
      main_d = '0;
      skid_d = '0;
    end else begin
      case (occ_q)
        EMPTY: begin
          if (accept) begin
            occ_d  = HALF;
            main_d = in_data;
          end
        end
        HALF: begin
          if (accept && deliver) begin
            main_d = in_data;
          end else if (accept) begin
            occ_d  = FULL;
            skid_d = in_data;
          end else if (deliver) begin
            occ_d  = EMPTY;
            main_d = '0;
          end
        end
        FULL: begin
          if (deliver) begin
            occ_d  = HALF;
            main_d = skid_q;
            skid_d = '0;
          end
        end
        default: begin
          occ_d  = EMPTY;
          main_d = '0;
          skid_d = '0;
        end
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .CLK   (CLK),
    .RST   (RST),
    .inc   (out_valid & ~out_ready & ~flush),
    .count (stall_cnt)
  );

endmodule
